// File: rtl/dmem_chk_pkg.sv
// rtl/dmem_chk_pkg.sv - shared state, error and table-entry types for the dmem write checker
package dmem_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_MISSING  = 2'd2,
        ERR_OVERRUN  = 2'd3
    } err_code_e;

    // Entries are stored at a fixed maximum width so the struct stays parameter-free.
    localparam int unsigned ENTRY_AW = 64;
    localparam int unsigned ENTRY_DW = 64;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [ENTRY_DW-1:0] data;
        logic                cnt;
    } entry_t;

endpackage

// File: rtl/dmem_wr_checker_if.sv
// rtl/dmem_wr_checker_if.sv - programming, start and store-tap bus of the dmem write checker
interface dmem_wr_checker_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  iprog_wr;
    logic [ADDR_WIDTH-1:0] iprog_addr;
    logic [DATA_WIDTH-1:0] iprog_data;
    logic                  iprog_cnt;
    logic                  istart;
    logic                  iwr_en;
    logic [ADDR_WIDTH-1:0] iwr_addr;
    logic [DATA_WIDTH-1:0] iwr_data;

    modport master (
        output iprog_wr, iprog_addr, iprog_data, iprog_cnt, istart,
        output iwr_en, iwr_addr, iwr_data
    );

    modport slave (
        input iprog_wr, iprog_addr, iprog_data, iprog_cnt, istart,
        input iwr_en, iwr_addr, iwr_data
    );
endinterface

// File: rtl/dmem_chk_table.sv
// rtl/dmem_chk_table.sv - expected-write table with candidate lookup; DMEM_CHK_OOO_EN selects out-of-order matching
module dmem_chk_table
    import dmem_chk_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 32,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned DEPTH      = 64,
    localparam int unsigned IDXW       = $clog2(DEPTH),
    localparam int unsigned CW         = IDXW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  prog_wr,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    input  logic                  prog_cnt,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic                  consume,
    output logic                  full,
    output logic                  cand_hit,
    output logic [IDXW-1:0]       cand_idx,
    output logic                  cand_cnt,
    output logic                  all_consumed,
    output logic [IDXW-1:0]       first_unc_idx
);

    entry_t              mem [DEPTH];
    logic [CW-1:0]       count;
    logic [ENTRY_AW-1:0] st_addr_x;
    logic [ENTRY_DW-1:0] st_data_x;

    assign st_addr_x = ENTRY_AW'(st_addr);
    assign st_data_x = ENTRY_DW'(st_data);
    assign full      = (count == CW'(DEPTH));
    assign cand_cnt  = mem[cand_idx].cnt;

    always_ff @(posedge clk) begin
        if (rst_n && prog_wr && !full) begin
            mem[count[IDXW-1:0]] <= '{addr: ENTRY_AW'(prog_addr),
                                      data: ENTRY_DW'(prog_data),
                                      cnt:  prog_cnt};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (prog_wr && !full) begin
            count <= count + CW'(1);
        end
    end

`ifdef DMEM_CHK_OOO_EN
    logic [DEPTH-1:0] consumed;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] hit;
    logic [IDXW-1:0]  hit_idx;

    // Descending scan leaves the lowest live / hitting index in the result.
    always_comb begin
        live          = '0;
        hit           = '0;
        hit_idx       = '0;
        first_unc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            live[i] = (CW'(i) < count) && !consumed[i];
            hit[i]  = live[i] && (mem[i].addr == st_addr_x) && (mem[i].data == st_data_x);
            if (live[i]) first_unc_idx = IDXW'(i);
            if (hit[i])  hit_idx       = IDXW'(i);
        end
    end

    assign cand_hit     = |hit;
    assign cand_idx     = cand_hit ? hit_idx : first_unc_idx;
    assign all_consumed = ~|live;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            consumed <= '0;
        end else if (consume) begin
            consumed[cand_idx] <= 1'b1;
        end
    end
`else
    logic [CW-1:0] rd_ptr;

    assign all_consumed  = (rd_ptr == count);
    assign cand_idx      = rd_ptr[IDXW-1:0];
    assign first_unc_idx = rd_ptr[IDXW-1:0];
    assign cand_hit      = !all_consumed
                        && (mem[cand_idx].addr == st_addr_x)
                        && (mem[cand_idx].data == st_data_x);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (consume) begin
            rd_ptr <= rd_ptr + CW'(1);
        end
    end
`endif

endmodule

// File: rtl/dmem_wr_checker.sv
// rtl/dmem_wr_checker.sv - data-memory store checker top: FSM, pass counter, error capture (DMEM_CHK_OOO_EN honoured by the table)
module dmem_wr_checker
    import dmem_chk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned IGN_BASE   = 96,
    parameter int unsigned IGN_SIZE   = 4,
    parameter int unsigned DONE_ADDR  = 40,
    parameter int unsigned DONE_DATA  = 30
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    dmem_wr_checker_if.slave         bus,
    output logic                     oprog_full,
    output logic [1:0]               ostate,
    output logic [$clog2(DEPTH):0]   opass_cnt,
    output logic [1:0]               oerr_code,
    output logic [$clog2(DEPTH)-1:0] oerr_idx,
    output logic [ADDR_WIDTH-1:0]    oerr_addr,
    output logic [DATA_WIDTH-1:0]    oerr_data
);

    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned CW   = IDXW + 1;
    localparam int unsigned AW1  = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0] IGN_LO = AW1'(IGN_BASE);
    localparam logic [AW1-1:0] IGN_HI = AW1'(IGN_BASE + IGN_SIZE);

    chk_state_e            state_q, state_d;
    err_code_e             err_code_q, err_code_d;
    logic [CW-1:0]         pass_q, pass_d;
    logic [IDXW-1:0]       err_idx_q, err_idx_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [DATA_WIDTH-1:0] err_data_q, err_data_d;

    logic            prog_accept, consume, full;
    logic            cand_hit, cand_cnt, all_consumed;
    logic [IDXW-1:0] cand_idx, first_unc_idx;
    logic            in_ign, is_done;

    // Extra top bit keeps IGN_BASE+IGN_SIZE from wrapping at the top of the address space.
    assign in_ign  = ({1'b0, bus.iwr_addr} >= IGN_LO) && ({1'b0, bus.iwr_addr} < IGN_HI);
    assign is_done = (bus.iwr_addr == ADDR_WIDTH'(DONE_ADDR))
                  && (bus.iwr_data == DATA_WIDTH'(DONE_DATA));
    assign prog_accept = (state_q == ST_IDLE) && bus.iprog_wr;

    dmem_chk_table #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_table (
        .clk           (iclk),
        .rst_n         (irst_n),
        .prog_wr       (prog_accept),
        .prog_addr     (bus.iprog_addr),
        .prog_data     (bus.iprog_data),
        .prog_cnt      (bus.iprog_cnt),
        .st_addr       (bus.iwr_addr),
        .st_data       (bus.iwr_data),
        .consume       (consume),
        .full          (full),
        .cand_hit      (cand_hit),
        .cand_idx      (cand_idx),
        .cand_cnt      (cand_cnt),
        .all_consumed  (all_consumed),
        .first_unc_idx (first_unc_idx)
    );

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            pass_q     <= '0;
            err_idx_q  <= '0;
            err_addr_q <= '0;
            err_data_q <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            pass_q     <= pass_d;
            err_idx_q  <= err_idx_d;
            err_addr_q <= err_addr_d;
            err_data_q <= err_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        pass_d     = pass_q;
        err_idx_d  = err_idx_q;
        err_addr_d = err_addr_q;
        err_data_d = err_data_q;
        consume    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.istart) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.iwr_en && !in_ign) begin
                    if (is_done && all_consumed) begin
                        state_d = ST_PASS;
                    end else if (is_done) begin
                        state_d    = ST_FAIL;
                        err_code_d = ERR_MISSING;
                        err_idx_d  = first_unc_idx;
                    end else if (all_consumed) begin
                        state_d    = ST_FAIL;
                        err_code_d = ERR_OVERRUN;
                    end else if (cand_hit) begin
                        consume = 1'b1;
                        if (cand_cnt) pass_d = pass_q + CW'(1);
                    end else begin
                        state_d    = ST_FAIL;
                        err_code_d = ERR_MISMATCH;
                        err_idx_d  = cand_idx;
                    end
                    if (state_d == ST_FAIL) begin
                        err_addr_d = bus.iwr_addr;
                        err_data_d = bus.iwr_data;
                    end
                end
            end
            default: ;
        endcase
    end

    assign oprog_full = full;
    assign ostate     = state_q;
    assign opass_cnt  = pass_q;
    assign oerr_code  = err_code_q;
    assign oerr_idx   = err_idx_q;
    assign oerr_addr  = err_addr_q;
    assign oerr_data  = err_data_q;

endmodule

// File: tb/tb_dmem_wr_checker.sv
// tb/tb_dmem_wr_checker.sv - vector table, directed corner cases and randomized stores against a queue-based model
module tb_dmem_wr_checker;

    localparam int DEPTH = 64;
    localparam int K_RST = 0, K_PROG = 1, K_START = 2, K_STORE = 3, K_PSTART = 4;
    localparam logic [1:0] S_I = 2'd0, S_R = 2'd1, S_P = 2'd2, S_F = 2'd3;

    logic        iclk = 1'b0;
    logic        irst_n = 1'b0;
    logic        oprog_full;
    logic [1:0]  ostate;
    logic [6:0]  opass_cnt;
    logic [1:0]  oerr_code;
    logic [5:0]  oerr_idx;
    logic [31:0] oerr_addr, oerr_data;

    dmem_wr_checker_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dmem_wr_checker dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .bus        (bus),
        .oprog_full (oprog_full),
        .ostate     (ostate),
        .opass_cnt  (opass_cnt),
        .oerr_code  (oerr_code),
        .oerr_idx   (oerr_idx),
        .oerr_addr  (oerr_addr),
        .oerr_data  (oerr_data)
    );

    always #5 iclk = ~iclk;

    int checks = 0;
    int errors = 0;

    // Reference model: expected table as queues plus a consumed flag per entry.
    logic [31:0] m_a[$], m_d[$];
    bit          m_c[$], m_u[$];
    int          m_state, m_pass, m_err, m_idx;
    logic [31:0] m_ea, m_ed;

    typedef struct {
        int          kind;
        logic [31:0] a, d;
        bit          c;
        logic [1:0]  es;
        int          ep;
        logic [1:0]  ee;
        int          ei;
        logic [31:0] ea, ed;
    } vec_t;
    vec_t vecs[$];

    function automatic void chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic int first_unused();
        for (int i = 0; i < m_a.size(); i++) if (!m_u[i]) return i;
        return -1;
    endfunction

    function automatic void m_fail(input int code, input int idx, input logic [31:0] a, input logic [31:0] d);
        m_state = S_F; m_err = code; m_idx = idx; m_ea = a; m_ed = d;
    endfunction

    function automatic void m_store(input logic [31:0] a, input logic [31:0] d);
        int fu, hit;
        if (a >= 96 && a < 100) return;
        fu = first_unused();
        if (a == 40 && d == 30) begin
            if (fu < 0) m_state = S_P;
            else m_fail(2, fu, a, d);
        end else if (fu < 0) begin
            m_fail(3, m_idx, a, d);
        end else begin
            hit = -1;
`ifdef DMEM_CHK_OOO_EN
            for (int i = 0; i < m_a.size(); i++)
                if (hit < 0 && !m_u[i] && m_a[i] == a && m_d[i] == d) hit = i;
`else
            if (m_a[fu] == a && m_d[fu] == d) hit = fu;
`endif
            if (hit >= 0) begin
                m_u[hit] = 1'b1;
                if (m_c[hit]) m_pass++;
            end else begin
                m_fail(1, fu, a, d);
            end
        end
    endfunction

    function automatic int pick_next();
        int fu = first_unused();
`ifdef DMEM_CHK_OOO_EN
        int cands[$];
        for (int i = 0; i < m_a.size(); i++) if (!m_u[i]) cands.push_back(i);
        if (cands.size() > 0) return cands[$urandom_range(0, cands.size() - 1)];
`endif
        return fu;
    endfunction

    function automatic void model_vs_dut(input string tag);
        chk({tag, ".state"}, ostate, m_state);
        chk({tag, ".pass"}, opass_cnt, m_pass);
        chk({tag, ".full"}, oprog_full, (m_a.size() == DEPTH) ? 1 : 0);
        chk({tag, ".err"}, oerr_code, m_err);
        chk({tag, ".idx"}, oerr_idx, m_idx);
        chk({tag, ".eaddr"}, oerr_addr, m_ea);
        chk({tag, ".edata"}, oerr_data, m_ed);
    endfunction

    task automatic clear_inputs();
        bus.iprog_wr = 0; bus.iprog_addr = 0; bus.iprog_data = 0; bus.iprog_cnt = 0;
        bus.istart = 0; bus.iwr_en = 0; bus.iwr_addr = 0; bus.iwr_data = 0;
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        irst_n = 1'b0;
        @(posedge iclk); #1;
        @(posedge iclk); #1;
        irst_n = 1'b1;
        m_a.delete(); m_d.delete(); m_c.delete(); m_u.delete();
        m_state = S_I; m_pass = 0; m_err = 0; m_idx = 0; m_ea = 0; m_ed = 0;
        model_vs_dut(tag);
    endtask

    task automatic step(input bit pw, input logic [31:0] pa, input logic [31:0] pd, input bit pc,
                        input bit st, input bit we, input logic [31:0] wa, input logic [31:0] wd,
                        input string tag);
        int prev;
        bus.iprog_wr = pw; bus.iprog_addr = pa; bus.iprog_data = pd; bus.iprog_cnt = pc;
        bus.istart = st; bus.iwr_en = we; bus.iwr_addr = wa; bus.iwr_data = wd;
        @(posedge iclk); #1;
        prev = m_state;
        if (prev == S_I) begin
            if (pw && m_a.size() < DEPTH) begin
                m_a.push_back(pa); m_d.push_back(pd); m_c.push_back(pc); m_u.push_back(1'b0);
            end
            if (st) m_state = S_R;
        end else if (prev == S_R && we) begin
            m_store(wa, wd);
        end
        clear_inputs();
        model_vs_dut(tag);
    endtask

    task automatic v(input int kind, input logic [31:0] a, input logic [31:0] d, input bit c,
                     input logic [1:0] es, input int ep, input logic [1:0] ee, input int ei,
                     input logic [31:0] ea, input logic [31:0] ed);
        vec_t r;
        r.kind = kind; r.a = a; r.d = d; r.c = c; r.es = es; r.ep = ep;
        r.ee = ee; r.ei = ei; r.ea = ea; r.ed = ed;
        vecs.push_back(r);
    endtask

    initial begin
        clear_inputs();

        // In-order full pass, then a store after PASS
        v(K_RST,   0, 0, 0,       S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  100, 25, 1,    S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  104, 4096, 1,  S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  108, 4184, 1,  S_I, 0, 0, 0, 0, 0);
        v(K_START, 0, 0, 0,       S_R, 0, 0, 0, 0, 0);
        v(K_STORE, 100, 25, 0,    S_R, 1, 0, 0, 0, 0);
        v(K_STORE, 104, 4096, 0,  S_R, 2, 0, 0, 0, 0);
        v(K_STORE, 108, 4184, 0,  S_R, 3, 0, 0, 0, 0);
        v(K_STORE, 40, 30, 0,     S_P, 3, 0, 0, 0, 0);
        v(K_STORE, 100, 25, 0,    S_P, 3, 0, 0, 0, 0);
        // Data mismatch on entry 1; FAIL is terminal
        v(K_RST,   0, 0, 0,       S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  100, 25, 1,    S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  104, 4096, 1,  S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  108, 4184, 1,  S_I, 0, 0, 0, 0, 0);
        v(K_START, 0, 0, 0,       S_R, 0, 0, 0, 0, 0);
        v(K_STORE, 100, 25, 0,    S_R, 1, 0, 0, 0, 0);
        v(K_STORE, 104, 4095, 0,  S_F, 1, 1, 1, 104, 4095);
        v(K_STORE, 108, 4184, 0,  S_F, 1, 1, 1, 104, 4095);
        v(K_PROG,  1, 2, 1,       S_F, 1, 1, 1, 104, 4095);
        // Scratch-window writes ignored, nocnt entry not counted
        v(K_RST,   0, 0, 0,       S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  160, 32'hFFFF_FFDD, 1, S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  164, 32'hFFFF_FFC0, 0, S_I, 0, 0, 0, 0, 0);
        v(K_START, 0, 0, 0,       S_R, 0, 0, 0, 0, 0);
        v(K_STORE, 96, 7, 0,      S_R, 0, 0, 0, 0, 0);
        v(K_STORE, 160, 32'hFFFF_FFDD, 0, S_R, 1, 0, 0, 0, 0);
        v(K_STORE, 99, 8, 0,      S_R, 1, 0, 0, 0, 0);
        v(K_STORE, 164, 32'hFFFF_FFC0, 0, S_R, 1, 0, 0, 0, 0);
        v(K_STORE, 97, 9, 0,      S_R, 1, 0, 0, 0, 0);
        v(K_STORE, 40, 30, 0,     S_P, 1, 0, 0, 0, 0);
        // Overrun after table exhausted
        v(K_RST,   0, 0, 0,       S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  200, 1, 1,     S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  204, 2, 1,     S_I, 0, 0, 0, 0, 0);
        v(K_START, 0, 0, 0,       S_R, 0, 0, 0, 0, 0);
        v(K_STORE, 200, 1, 0,     S_R, 1, 0, 0, 0, 0);
        v(K_STORE, 204, 2, 0,     S_R, 2, 0, 0, 0, 0);
        v(K_STORE, 116, 1, 0,     S_F, 2, 3, 0, 116, 1);
        // Sentinel with an entry still missing
        v(K_RST,   0, 0, 0,       S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  200, 1, 1,     S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  204, 2, 1,     S_I, 0, 0, 0, 0, 0);
        v(K_START, 0, 0, 0,       S_R, 0, 0, 0, 0, 0);
        v(K_STORE, 200, 1, 0,     S_R, 1, 0, 0, 0, 0);
        v(K_STORE, 40, 30, 0,     S_F, 1, 2, 1, 40, 30);
        // Empty table, and address 100 just past the scratch window
        v(K_RST,   0, 0, 0,       S_I, 0, 0, 0, 0, 0);
        v(K_START, 0, 0, 0,       S_R, 0, 0, 0, 0, 0);
        v(K_STORE, 40, 30, 0,     S_P, 0, 0, 0, 0, 0);
        v(K_RST,   0, 0, 0,       S_I, 0, 0, 0, 0, 0);
        v(K_START, 0, 0, 0,       S_R, 0, 0, 0, 0, 0);
        v(K_STORE, 100, 5, 0,     S_F, 0, 3, 0, 100, 5);
        // Program and start in the same cycle
        v(K_RST,   0, 0, 0,       S_I, 0, 0, 0, 0, 0);
        v(K_PSTART, 300, 5, 1,    S_R, 0, 0, 0, 0, 0);
        v(K_STORE, 300, 5, 0,     S_R, 1, 0, 0, 0, 0);
        v(K_STORE, 40, 30, 0,     S_P, 1, 0, 0, 0, 0);
        // Reversed order: accepted only with out-of-order matching
        v(K_RST,   0, 0, 0,       S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  100, 25, 1,    S_I, 0, 0, 0, 0, 0);
        v(K_PROG,  104, 4096, 1,  S_I, 0, 0, 0, 0, 0);
        v(K_START, 0, 0, 0,       S_R, 0, 0, 0, 0, 0);
`ifdef DMEM_CHK_OOO_EN
        v(K_STORE, 104, 4096, 0,  S_R, 1, 0, 0, 0, 0);
        v(K_STORE, 100, 25, 0,    S_R, 2, 0, 0, 0, 0);
        v(K_STORE, 40, 30, 0,     S_P, 2, 0, 0, 0, 0);
`else
        v(K_STORE, 104, 4096, 0,  S_F, 0, 1, 0, 104, 4096);
        v(K_STORE, 100, 25, 0,    S_F, 0, 1, 0, 104, 4096);
        v(K_STORE, 40, 30, 0,     S_F, 0, 1, 0, 104, 4096);
`endif

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            case (vecs[i].kind)
                K_RST:    do_reset(t);
                K_PROG:   step(1, vecs[i].a, vecs[i].d, vecs[i].c, 0, 0, 0, 0, t);
                K_START:  step(0, 0, 0, 0, 1, 0, 0, 0, t);
                K_PSTART: step(1, vecs[i].a, vecs[i].d, vecs[i].c, 1, 0, 0, 0, t);
                default:  step(0, 0, 0, 0, 0, 1, vecs[i].a, vecs[i].d, t);
            endcase
            chk({t, ".tstate"}, ostate, vecs[i].es);
            chk({t, ".tpass"}, opass_cnt, vecs[i].ep);
            chk({t, ".terr"}, oerr_code, vecs[i].ee);
            chk({t, ".tidx"}, oerr_idx, vecs[i].ei);
            chk({t, ".teaddr"}, oerr_addr, vecs[i].ea);
            chk({t, ".tedata"}, oerr_data, vecs[i].ed);
        end

        // Overfill: the DEPTH+1-th entry must be dropped
        do_reset("full.rst");
        for (int i = 0; i <= DEPTH; i++) begin
            step(1, 32'(2000 + 4 * i), 32'(i), i[0], 0, 0, 0, 0, "full.prog");
            if (i == DEPTH - 2) chk("full.before", oprog_full, 0);
        end
        chk("full.after", oprog_full, 1);
        step(0, 0, 0, 0, 1, 0, 0, 0, "full.start");
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 1, 32'(2000 + 4 * i), 32'(i), "full.st");
        step(0, 0, 0, 0, 0, 1, 40, 30, "full.done");
        chk("full.verdict", ostate, S_P);
        chk("full.passcnt", opass_cnt, DEPTH / 2);

        // Reset in the middle of RUN empties the table
        do_reset("mid.rst0");
        step(1, 500, 1, 1, 0, 0, 0, 0, "mid.p0");
        step(1, 504, 2, 1, 1, 0, 0, 0, "mid.p1");
        step(0, 0, 0, 0, 0, 1, 500, 1, "mid.s0");
        chk("mid.running", opass_cnt, 1);
        do_reset("mid.rst1");
        chk("mid.state", ostate, S_I);
        chk("mid.pass", opass_cnt, 0);
        chk("mid.full", oprog_full, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, "mid.start");
        step(0, 0, 0, 0, 0, 1, 40, 30, "mid.done");
        chk("mid.empty_pass", ostate, S_P);

        // Randomized programs and store streams against the model
        for (int it = 0; it < 25; it++) begin
            int n;
            do_reset("rnd.rst");
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++)
                step(1, 32'(200 + 4 * $urandom_range(0, 5)), 32'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), (k == n - 1) && ($urandom_range(0, 1) == 1),
                     0, 0, 0, "rnd.prog");
            step(0, 0, 0, 0, 1, 0, 0, 0, "rnd.start");
            for (int s = 0; s < 20; s++) begin
                int r, nx;
                r = $urandom_range(0, 9);
                nx = pick_next();
                if (r <= 4 && nx >= 0)
                    step(0, 0, 0, 0, 0, 1, m_a[nx], m_d[nx], "rnd.exp");
                else if (r == 5)
                    step(0, 0, 0, 0, 0, 1, 32'(96 + $urandom_range(0, 3)), $urandom, "rnd.ign");
                else if (r == 6)
                    step(0, 0, 0, 0, 0, 1, 40, 30, "rnd.done");
                else if (r == 7)
                    step(0, 0, 0, 0, 0, 1, 32'(200 + 4 * $urandom_range(0, 5)),
                         32'($urandom_range(0, 3)), "rnd.pool");
                else if (r == 8)
                    step(1, 200, 0, 1, 1, 1, 32'(200 + 4 * $urandom_range(0, 5)),
                         32'($urandom_range(0, 3)), "rnd.noise");
                else
                    step(0, 0, 0, 0, 0, 0, 0, 0, "rnd.idle");
            end
            step(0, 0, 0, 0, 0, 1, 40, 30, "rnd.final");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_wr_checker.md
# dmem_wr_checker

Synthesizable self-check monitor for the RISC-V core's data-memory write port. Compares every committed store (address, data) against a programmable table of expected writes, counts passing checks, skips scratch-window writes, and finishes on a sentinel store with a pass/fail verdict. Sits beside `top`, tapping `odmem_wr_en`/`odmem_addr`/`odmem_wr_data`. Usable in simulation and on FPGA, where the status outputs drive LEDs or a debug UART.

## Interface
- DATA_WIDTH, 32, store data width
- ADDR_WIDTH, 32, store address width
- DEPTH, 64, expected-table entries (power of two, ≥2)
- IGN_BASE, 96, first address of ignored scratch window
- IGN_SIZE, 4, ignored window length in bytes (0 disables)
- DONE_ADDR, 40, sentinel address
- DONE_DATA, 30, sentinel data
---
- iclk  in  1  clock
- irst_n  in  1  reset; synchronous, active-low
- iprog_wr  in  1  append one expected entry
- iprog_addr  in  ADDR_WIDTH  expected address
- iprog_data  in  DATA_WIDTH  expected data
- iprog_cnt  in  1  entry increments pass count when matched
- istart  in  1  arm checker
- iwr_en  in  1  store strobe from core
- iwr_addr  in  ADDR_WIDTH  store address
- iwr_data  in  DATA_WIDTH  store data
- oprog_full  out  1  table full
- ostate  out  2  IDLE=0, RUN=1, PASS=2, FAIL=3
- opass_cnt  out  $clog2(DEPTH)+1  counted matches
- oerr_code  out  2  0 none, 1 mismatch, 2 missing, 3 overrun
- oerr_idx  out  $clog2(DEPTH)  table index at failure
- oerr_addr  out  ADDR_WIDTH  offending store address
- oerr_data  out  DATA_WIDTH  offending store data

## Operation
- Reset: ostate=IDLE, table count=0, opass_cnt=0, oerr_*=0, oprog_full=0, consumed bits cleared.
- IDLE: iprog_wr appends at index = count, count++; when count==DEPTH, oprog_full=1 and further iprog_wr dropped. istart → RUN (same-cycle iprog_wr still accepted). iwr_en ignored.
- RUN, per iwr_en, priority order:
  1. addr in [IGN_BASE, IGN_BASE+IGN_SIZE): ignored.
  2. addr==DONE_ADDR && data==DONE_DATA: all count entries consumed → PASS; else FAIL code 2, oerr_idx = first unconsumed index.
  3. All entries consumed: FAIL code 3.
  4. Compare against candidate entry: match → consume, opass_cnt++ if entry's cnt bit set; no match → FAIL code 1, oerr_idx = candidate index.
- oerr_addr/oerr_data capture the offending store on any FAIL; unchanged otherwise.
- PASS/FAIL are terminal until reset; istart, iprog_wr, iwr_en ignored.
- Empty table (count=0) + istart + sentinel → PASS with opass_cnt=0.
- Reset mid-RUN: everything returns to reset values, table emptied.

## Timing
- All outputs registered; store at cycle N visible in ostate/counters at N+1.
- One store per cycle accepted, back-to-back, no stall, no backpressure.
- Programming: one entry per cycle; oprog_full asserts the cycle after the DEPTH-th write.
- istart and iprog_wr in RUN/PASS/FAIL have no effect.

## Configuration
- DMEM_CHK_OOO_EN defined: out-of-order match; candidate = lowest-index unconsumed entry whose addr and data both equal the store; no such entry → mismatch with oerr_idx = lowest unconsumed index. Compare is parallel over all DEPTH entries, still single-cycle.
- Undefined: strict in-order; candidate = entry at read pointer, pointer increments on match; consumed set = indices below pointer.

## Structure
- Package dmem_chk_pkg: state enum, err_code enum, entry struct {addr, data, cnt}, ERR_* constants.
- Sub-module dmem_chk_table: entry storage, count, consumed tracking, candidate/first-unconsumed lookup (in-order pointer or OOO priority encoder). FSM, counters, error capture in dmem_wr_checker.

## Test plan
- Program (100,25,cnt),(104,4096,cnt),(108,4184,cnt); start; store those in order, then (40,30) → PASS, opass_cnt=3, oerr_code=0.
- Same table; store (100,25),(104,4095) → FAIL, oerr_code=1, oerr_idx=1, oerr_addr=104, oerr_data=4095; later stores no effect.
- Table (160,-35,cnt),(164,-64,nocnt); stores interleaved with writes to 96..99, then sentinel → PASS, opass_cnt=1.
- Table of 2; store both, then (116,1) → FAIL code 3; separately, one store then sentinel → FAIL code 2, oerr_idx=1.
- Program DEPTH+1 entries → oprog_full=1 after DEPTH, extra dropped; reset mid-RUN → ostate=IDLE, opass_cnt=0, oprog_full=0.
- DMEM_CHK_OOO_EN: table (100,25),(104,4096); store reversed then sentinel → PASS; without macro same stimulus → FAIL code 1, oerr_idx=0.
